dcache_flush_unit: RTL and testbench



---
 rtl/dcache_flush_unit_if.sv | 40 ++++
 rtl/dcache_flush_unit.sv | 122 ++++++++++++
 tb/tb_dcache_flush_unit.sv | 378 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_flush_unit_if.sv
// Tag array and write-back port bundle of the D-cache flush unit.
// master = flush unit, slave = tag arbiter plus write-back unit.
interface dcache_flush_unit_if #(
  parameter int NUM_SETS = 256,
  parameter int NUM_WAYS = 8,
  parameter int TAG_W    = 44,
  parameter int OFFSET_W = 4
);
  localparam int INDEX_W = $clog2(NUM_SETS);
  localparam int ADDR_W  = TAG_W + INDEX_W + OFFSET_W;

  logic                      tag_req_o;
  logic                      tag_we_o;
  logic [INDEX_W-1:0]        tag_index_o;
  logic [NUM_WAYS-1:0]       tag_way_o;
  logic                      tag_gnt_i;
  logic [NUM_WAYS-1:0]       tag_valid_i;
  logic [NUM_WAYS-1:0]       tag_dirty_i;
  logic [NUM_WAYS*TAG_W-1:0] tag_i;

  logic                      wb_req_o;
  logic [ADDR_W-1:0]         wb_addr_o;
  logic [NUM_WAYS-1:0]       wb_way_o;
  logic                      wb_gnt_i;
  logic                      wb_done_i;

  modport master (
    output tag_req_o, tag_we_o, tag_index_o, tag_way_o,
    input  tag_gnt_i, tag_valid_i, tag_dirty_i, tag_i,
    output wb_req_o, wb_addr_o, wb_way_o,
    input  wb_gnt_i, wb_done_i
  );

  modport slave (
    input  tag_req_o, tag_we_o, tag_index_o, tag_way_o,
    output tag_gnt_i, tag_valid_i, tag_dirty_i, tag_i,
    input  wb_req_o, wb_addr_o, wb_way_o,
    output wb_gnt_i, wb_done_i
  );
endinterface

// File: rtl/dcache_flush_unit.sv
// D-cache flush responder: walks every set, writes back
// valid+dirty ways, invalidates the set, then pulses ack.
module dcache_flush_unit #(
  parameter int NUM_SETS = 256,
  parameter int NUM_WAYS = 8,
  parameter int TAG_W    = 44,
  parameter int OFFSET_W = 4,
  parameter int ADDR_W   = TAG_W + $clog2(NUM_SETS) + OFFSET_W
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                flush_i,
  output logic                flush_ack_o,
  output logic                busy_o,
  dcache_flush_unit_if.master bus
);
  localparam int INDEX_W = $clog2(NUM_SETS);

  typedef enum logic [2:0] {
    IDLE, READ, CAPTURE, WB_REQ, WB_WAIT, INV, ACK
  } state_e;

  state_e                    state_q, state_d;
  logic [INDEX_W-1:0]        index_q, index_d;
  logic [NUM_WAYS-1:0]       pend_q, pend_d;
  logic [NUM_WAYS*TAG_W-1:0] tags_q;
  logic [NUM_WAYS-1:0]       sel;
  logic [TAG_W-1:0]          sel_tag;
  logic [ADDR_W-1:0]         line_addr;

  // lowest pending way; pending only changes in WB_WAIT,
  // so the selection is stable through WB_REQ
  assign sel = pend_q & (~pend_q + NUM_WAYS'(1));

  always_comb begin
    sel_tag = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (sel[w]) sel_tag = tags_q[w*TAG_W +: TAG_W];
    end
  end

  assign line_addr = ADDR_W'({sel_tag, index_q,
                              {OFFSET_W{1'b0}}});

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      index_q <= '0;
      pend_q  <= '0;
      tags_q  <= '0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      pend_q  <= pend_d;
      if (state_q == CAPTURE) tags_q <= bus.tag_i;
    end
  end

  always_comb begin
    state_d         = state_q;
    index_d         = index_q;
    pend_d          = pend_q;
    flush_ack_o     = 1'b0;
    busy_o          = (state_q != IDLE);
    bus.tag_req_o   = 1'b0;
    bus.tag_we_o    = 1'b0;
    bus.tag_index_o = '0;
    bus.tag_way_o   = '0;
    bus.wb_req_o    = 1'b0;
    bus.wb_addr_o   = '0;
    bus.wb_way_o    = '0;
    unique case (state_q)
      IDLE: begin
        if (flush_i) begin
          state_d = READ;
          index_d = '0;
        end
      end
      READ: begin
        bus.tag_req_o   = 1'b1;
        bus.tag_index_o = index_q;
        if (bus.tag_gnt_i) state_d = CAPTURE;
      end
      CAPTURE: begin
        pend_d  = bus.tag_valid_i & bus.tag_dirty_i;
        state_d = (pend_d != '0) ? WB_REQ : INV;
      end
      WB_REQ: begin
        bus.wb_req_o  = 1'b1;
        bus.wb_addr_o = line_addr;
        bus.wb_way_o  = sel;
        if (bus.wb_gnt_i) state_d = WB_WAIT;
      end
      WB_WAIT: begin
        if (bus.wb_done_i) begin
          pend_d  = pend_q & ~sel;
          state_d = (pend_d != '0) ? WB_REQ : INV;
        end
      end
      INV: begin
        bus.tag_req_o   = 1'b1;
        bus.tag_we_o    = 1'b1;
        bus.tag_index_o = index_q;
        bus.tag_way_o   = '1;
        if (bus.tag_gnt_i) begin
          if (index_q == INDEX_W'(NUM_SETS - 1)) begin
            index_d = '0;
            state_d = ACK;
          end else begin
            index_d = index_q + INDEX_W'(1);
            state_d = READ;
          end
        end
      end
      ACK: begin
        flush_ack_o = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_dcache_flush_unit.sv
// Bench for dcache_flush_unit: tag-array and write-back
// responders around a cache-content model and wb scoreboard.
module tb_dcache_flush_unit;
  localparam int S  = 4;
  localparam int W  = 2;
  localparam int TW = 8;
  localparam int OW = 4;
  localparam int IW = 2;
  localparam int AW = TW + IW + OW;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic ack;
  logic busy;

  dcache_flush_unit_if #(
    .NUM_SETS(S), .NUM_WAYS(W), .TAG_W(TW), .OFFSET_W(OW)
  ) bus ();

  dcache_flush_unit #(
    .NUM_SETS(S), .NUM_WAYS(W), .TAG_W(TW),
    .OFFSET_W(OW), .ADDR_W(AW)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .flush_ack_o(ack), .busy_o(busy), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            set;
    int            way;
    logic [AW-1:0] addr;
  } wb_t;

  int ntests = 0;
  int nfail  = 0;

  logic          mv [S][W];
  logic          md [S][W];
  logic [TW-1:0] mt [S][W];
  wb_t           expq [$];

  bit cfg_rand      = 1'b0;
  bit cfg_spur      = 1'b0;
  int cfg_stall_set = -1;
  int cfg_stall_len = 0;
  int cfg_wb_g      = 0;
  int cfg_wb_d      = 3;

  int            tcnt = -1;
  int            wcnt = -1;
  int            dcnt = 0;
  bit            outstanding = 1'b0;
  bit            rd_pend = 1'b0;
  int            rd_idx = 0;
  int            extra = 0;
  int            exp_idx = 0;
  int            n_wb = 0;
  logic          snap_we;
  logic [IW-1:0] snap_idx;
  logic [AW-1:0] snap_addr;
  logic [W-1:0]  snap_way;
  logic [AW-1:0] last_wb_addr;
  logic [W-1:0]  last_wb_way;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic clear_mem();
    for (int s = 0; s < S; s++)
      for (int w = 0; w < W; w++) begin
        mv[s][w] = 1'b0;
        md[s][w] = 1'b0;
        mt[s][w] = '0;
      end
  endtask

  task automatic rand_mem();
    for (int s = 0; s < S; s++)
      for (int w = 0; w < W; w++) begin
        mv[s][w] = 1'($urandom);
        md[s][w] = 1'($urandom);
        mt[s][w] = TW'($urandom);
      end
  endtask

  // every valid+dirty line, in set order then way order
  task automatic build_expq();
    wb_t e;
    expq.delete();
    for (int s = 0; s < S; s++)
      for (int w = 0; w < W; w++)
        if (mv[s][w] && md[s][w]) begin
          e.set  = s;
          e.way  = w;
          e.addr = AW'(mt[s][w]) * AW'(1 << (IW + OW))
                 + AW'(s) * AW'(1 << OW);
          expq.push_back(e);
        end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ack"}, 64'(ack), 64'(0));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_treq"}, 64'(bus.tag_req_o), 64'(0));
    chk({tag, "_twe"}, 64'(bus.tag_we_o), 64'(0));
    chk({tag, "_tidx"}, 64'(bus.tag_index_o), 64'(0));
    chk({tag, "_tway"}, 64'(bus.tag_way_o), 64'(0));
    chk({tag, "_wreq"}, 64'(bus.wb_req_o), 64'(0));
    chk({tag, "_waddr"}, 64'(bus.wb_addr_o), 64'(0));
    chk({tag, "_wway"}, 64'(bus.wb_way_o), 64'(0));
  endtask

  // responders: act at negedge, seen by the DUT at the next posedge
  initial begin : responder
    int d;
    bit left;
    wb_t e;
    bus.tag_gnt_i   = 1'b0;
    bus.tag_valid_i = '0;
    bus.tag_dirty_i = '0;
    bus.tag_i       = '0;
    bus.wb_gnt_i    = 1'b0;
    bus.wb_done_i   = 1'b0;
    forever begin
      @(negedge clk);
      bus.tag_gnt_i = 1'b0;
      bus.wb_gnt_i  = 1'b0;
      bus.wb_done_i = 1'b0;
      if (!rst_n) begin
        tcnt = -1;
        wcnt = -1;
        dcnt = 0;
        outstanding = 1'b0;
        rd_pend = 1'b0;
      end else begin
        if (rd_pend) begin
          for (int w = 0; w < W; w++) begin
            bus.tag_valid_i[w]        = mv[rd_idx][w];
            bus.tag_dirty_i[w]        = md[rd_idx][w];
            bus.tag_i[w*TW +: TW]     = mt[rd_idx][w];
          end
        end else begin
          bus.tag_valid_i = W'($urandom);
          bus.tag_dirty_i = W'($urandom);
          bus.tag_i       = (W*TW)'($urandom);
        end
        rd_pend = 1'b0;

        if (bus.tag_req_o) begin
          if (tcnt < 0) begin
            if (cfg_rand) tcnt = $urandom_range(0, 2);
            else tcnt = (cfg_stall_set == exp_idx)
                        ? cfg_stall_len : 0;
            snap_we  = bus.tag_we_o;
            snap_idx = bus.tag_index_o;
          end
          chk("tag_we_stable", 64'(bus.tag_we_o), 64'(snap_we));
          chk("tag_idx_stable", 64'(bus.tag_index_o),
              64'(snap_idx));
          if (tcnt > 0) begin
            tcnt--;
            extra++;
          end else begin
            bus.tag_gnt_i = 1'b1;
            tcnt = -1;
            chk("tag_index", 64'(bus.tag_index_o), 64'(exp_idx));
            if (bus.tag_we_o) begin
              chk("inv_way", 64'(bus.tag_way_o), 64'((1 << W) - 1));
              left = (expq.size() != 0) && (expq[0].set == exp_idx);
              chk("inv_after_wb", 64'(left), 64'(0));
              for (int w = 0; w < W; w++) begin
                mv[exp_idx % S][w] = 1'b0;
                md[exp_idx % S][w] = 1'b0;
              end
              exp_idx++;
            end else begin
              rd_pend = 1'b1;
              rd_idx  = exp_idx % S;
            end
          end
        end else begin
          tcnt = -1;
        end

        if (outstanding) begin
          dcnt--;
          if (dcnt == 0) begin
            bus.wb_done_i = 1'b1;
            outstanding = 1'b0;
          end
        end else if (cfg_spur && $urandom_range(0, 5) == 0) begin
          bus.wb_done_i = 1'b1;
        end

        if (bus.wb_req_o) begin
          if (wcnt < 0) begin
            wcnt = cfg_rand ? $urandom_range(0, 2) : cfg_wb_g;
            snap_addr = bus.wb_addr_o;
            snap_way  = bus.wb_way_o;
          end
          chk("wb_addr_stable", 64'(bus.wb_addr_o), 64'(snap_addr));
          chk("wb_way_stable", 64'(bus.wb_way_o), 64'(snap_way));
          if (wcnt > 0) begin
            wcnt--;
            extra++;
          end else begin
            bus.wb_gnt_i = 1'b1;
            wcnt = -1;
            if (expq.size() == 0) begin
              chk("wb_unexpected", 64'(1), 64'(0));
            end else begin
              e = expq.pop_front();
              chk("wb_set", 64'(e.set), 64'(exp_idx));
              chk("wb_addr", 64'(bus.wb_addr_o), 64'(e.addr));
              chk("wb_way", 64'(bus.wb_way_o), 64'(1 << e.way));
            end
            d = cfg_rand ? $urandom_range(1, 4) : cfg_wb_d;
            dcnt = d;
            outstanding = 1'b1;
            extra += 1 + d;
            n_wb++;
            last_wb_addr = bus.wb_addr_o;
            last_wb_way  = bus.wb_way_o;
          end
        end else begin
          wcnt = -1;
        end
      end
    end
  end

  // called at a negedge; that cycle is cycle 0
  task automatic do_walk(input int drop_at, output int ack_at);
    int cyc;
    int acks;
    int nvalid;
    exp_idx = 0;
    extra   = 0;
    n_wb    = 0;
    build_expq();
    chk("idle_busy", 64'(busy), 64'(0));
    flush  = 1'b1;
    acks   = 0;
    ack_at = -1;
    cyc    = 0;
    while (cyc < 500 && (ack_at < 0 || cyc < ack_at + 3)) begin
      @(negedge clk);
      cyc++;
      if (drop_at > 0 && cyc == drop_at) flush = 1'b0;
      if (ack_at >= 0 && cyc == ack_at + 1) flush = 1'b0;
      if (ack) begin
        acks++;
        if (ack_at < 0) ack_at = cyc;
      end
      chk("busy", 64'(busy), 64'((ack_at < 0) || (cyc == ack_at)));
    end
    flush = 1'b0;
    chk("ack_cycle", 64'(ack_at), 64'(1 + 3 * S + extra));
    chk("ack_count", 64'(acks), 64'(1));
    chk("wb_remaining", 64'(expq.size()), 64'(0));
    nvalid = 0;
    for (int s = 0; s < S; s++)
      for (int w = 0; w < W; w++)
        if (mv[s][w] || md[s][w]) nvalid++;
    chk("cache_clean", 64'(nvalid), 64'(0));
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int ack_at;
    int k;
    clear_mem();
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // all clean, grants immediate
    do_walk(0, ack_at);
    chk("t1_ack13", 64'(ack_at), 64'(13));
    chk("t1_nwb", 64'(n_wb), 64'(0));

    // one dirty line: set 2 way 1 tag 0x5
    clear_mem();
    mv[2][1] = 1'b1;
    md[2][1] = 1'b1;
    mt[2][1] = 8'h05;
    do_walk(0, ack_at);
    chk("t2_ack17", 64'(ack_at), 64'(17));
    chk("t2_nwb", 64'(n_wb), 64'(1));
    chk("t2_addr", 64'(last_wb_addr), 64'(14'h160));
    chk("t2_way", 64'(last_wb_way), 64'(2'b10));

    // set 0 both dirty; set 1 valid-clean and invalid-dirty
    clear_mem();
    mv[0][0] = 1'b1; md[0][0] = 1'b1; mt[0][0] = 8'h11;
    mv[0][1] = 1'b1; md[0][1] = 1'b1; mt[0][1] = 8'h22;
    mv[1][0] = 1'b1; md[1][0] = 1'b0; mt[1][0] = 8'h33;
    mv[1][1] = 1'b0; md[1][1] = 1'b1; mt[1][1] = 8'h44;
    do_walk(0, ack_at);
    chk("t3_ack21", 64'(ack_at), 64'(21));
    chk("t3_nwb", 64'(n_wb), 64'(2));

    // 5-cycle grant stalls on set 1 read and invalidate
    clear_mem();
    cfg_stall_set = 1;
    cfg_stall_len = 5;
    do_walk(0, ack_at);
    chk("t4_ack23", 64'(ack_at), 64'(23));
    cfg_stall_set = -1;

    // reset while waiting on write-back completion
    clear_mem();
    mv[1][0] = 1'b1; md[1][0] = 1'b1; mt[1][0] = 8'h3c;
    cfg_wb_d = 20;
    exp_idx = 0;
    extra = 0;
    build_expq();
    flush = 1'b1;
    k = 0;
    while (!outstanding && k < 100) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk("t5_in_wbwait", 64'(outstanding), 64'(1));
    rst_n = 1'b0;
    flush = 1'b0;
    #1;
    chk_all_zero("t5_rst");
    repeat (2) begin
      @(negedge clk);
      chk("t5_no_ack", 64'(ack), 64'(0));
    end
    rst_n = 1'b1;
    cfg_wb_d = 3;
    @(negedge clk);
    do_walk(0, ack_at);
    chk("t5_ack17", 64'(ack_at), 64'(17));
    chk("t5_nwb", 64'(n_wb), 64'(1));

    // flush dropped mid-walk, then a second full walk
    clear_mem();
    do_walk(3, ack_at);
    chk("t6_ack13", 64'(ack_at), 64'(13));
    @(negedge clk);
    rand_mem();
    do_walk(0, ack_at);

    // randomized contents, stalls and stray done pulses
    cfg_rand = 1'b1;
    cfg_spur = 1'b1;
    for (int i = 0; i < 25; i++) begin
      rand_mem();
      @(negedge clk);
      do_walk(0, ack_at);
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
